r2sdf_seq_ctrl: RTL and testbench
=================================

Name: r2sdf_seq_ctrl

Overview:
- Central sequencer for an N-stage radix-2 single-path delay-feedback (R2SDF) FFT pipeline of bf_stage-style butterfly stages.
- Replaces per-stage free-running control with one frame counter. Generates per-stage enables, shift/butterfly selects, twiddle ROM addresses and frame start/done strobes.
- Sits between the sample source's frame-start strobe and the stage datapaths.

Parameters:
- N, 3: log2 FFT size, 2^N points per frame; legal range 2..10.
- CW, N+1: width of internal global counter g; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_ip  input  1  one-cycle pulse; sample 0 of a new frame is presented to stage 1 in the next cycle
- stage_en  output  N  bit n-1 high when stage n processes a valid sample this cycle
- stage_sel  output  N  bit n-1: 0 = shift/fill (load delay line, output buffered value), 1 = butterfly
- tw_addr  output  N*(N-1)  field n-1, bits [(n)(N-1)-1:(n-1)(N-1)], is the cos/sin ROM index for stage n; 0 when stage_sel bit is 0
- start_op  output  1  one-cycle pulse coincident with the first output sample of each frame leaving stage N
- busy  output  1  high in RUN or DRAIN
- err_overrun  output  1  one-cycle pulse when start_ip is rejected

Behaviour:
- Reset (rst=1 at posedge): state IDLE; counters 0; all outputs 0. Reset mid-frame aborts the frame immediately; no start_op.
- All outputs are registered and change only on posedge clk.
- States: IDLE, RUN, DRAIN.
  - IDLE: start_ip=1 -> RUN, g=0.
  - RUN: g increments each cycle. At g[N-1:0]==2^N-1 with start_ip=1 the next frame begins back-to-back and the state stays RUN. At the same point with start_ip=0 -> DRAIN.
  - DRAIN: runs for 2^N-1 cycles, then -> IDLE.
- start_ip in RUN at any other counter value is ignored: err_overrun pulses and counters are undisturbed. start_ip in DRAIN restarts a frame (state RUN, new frame index 0) while older frames continue to drain correctly. Stage timing is derived from g modulo per-stage offsets, so overlap is lossless.
- Stage offset: L_n = 2^N - 2^(N-n+1), so stage n's first sample is L_n cycles after stage 1's. Local count l_n = (g - L_n) mod 2^N.
- stage_en bit n-1 = 1 iff a frame sample exists at stage n, i.e. g >= L_n within any live frame. In DRAIN it drops per stage after that stage's final sample.
- Delay line length: D_n = 2^(N-n).
- stage_sel bit n-1 = bit (N-n) of l_n. The first D_n samples of each 2*D_n group are 0 (fill); the next D_n are 1 (butterfly).
- Twiddle: k = l_n >> (N-n+1), which is n-1 bits. tw_addr field = bitrev_{n-1}(k) << (N-n), which is N-1 bits. Stage 1 is always 0.
- start_op pulses when the counter reaches global cycle f*2^N + 2^N - 1 for each frame f. Total pipeline latency is 2^N-1 cycles.
- busy = (state != IDLE).

Optional Feature:
- Macro R2SDF_FRAME_CNT_EN.
- When defined: adds output frame_cnt (16 bits). It is reset to 0 and increments by 1 on every start_op pulse, wrapping from 65535 to 0.
- When undefined: the port and its logic are absent.

Test Plan:
- rst, then a single start_ip with N=3 -> stage_en bits 0/1/2 rise 1/5/7 cycles after the pulse (L = 0, 4, 6). start_op pulses 8 cycles after start_ip (1 + 7). busy falls 16 cycles after start_ip (1 + 8 + 7).
- Same run, stage 1 -> stage_sel[0] = 0,0,0,0,1,1,1,1 per frame with tw_addr field0 = 0. Stage 3 tw_addr field2 = 0,0,2,2,1,1,3,3 over l = 0..7, valid only when sel=1.
- Back-to-back frames: start_ip at cycles 0 and 8 -> busy stays high with no gap. start_op at cycles 8 and 16. No err_overrun.
- start_ip at cycle 3 of a running frame -> err_overrun pulses at cycle 4 and frame timing is unchanged.
- rst asserted at g=5 -> all outputs 0 next cycle, state IDLE, no start_op afterward.
- With R2SDF_FRAME_CNT_EN: 3 back-to-back frames -> frame_cnt reads 3 after the final start_op.

Source files
------------

// File: rtl/r2sdf_seq_ctrl.sv
// Central frame sequencer for an N-stage radix-2 SDF FFT pipeline: stage enables, selects,
// twiddle addresses and frame strobes. Define R2SDF_FRAME_CNT_EN to add the frame_cnt output.
module r2sdf_seq_ctrl #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_ip,
    output logic [N-1:0]       stage_en,
    output logic [N-1:0]       stage_sel,
    output logic [N*(N-1)-1:0] tw_addr,
    output logic               start_op,
    output logic               busy,
    output logic               err_overrun
`ifdef R2SDF_FRAME_CNT_EN
    ,
    output logic [15:0]        frame_cnt
`endif
);

    localparam int CW = N + 1;
    localparam int TW = N - 1;
    localparam logic [N-1:0] FrameEnd = '1;
    localparam logic [N-1:0] DrainEnd = {{(N-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          g_q, g_d;
    logic [N-1:0]           act_q, act_d;
    logic [N-1:0][N-1:0]    l_q, l_d;
    logic [N-1:0]           sel_q, sel_d;
    logic [N-1:0][TW-1:0]   tw_q, tw_d;
    logic                   sop_q, sop_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   launch;
    logic [N-1:0]           stage_start;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        launch  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ip) begin
                    state_d = StRun;
                    g_d     = '0;
                    launch  = 1'b1;
                end
            end
            StRun: begin
                g_d = g_q + CW'(1);
                if (g_q[N-1:0] == FrameEnd) begin
                    if (start_ip) begin
                        launch = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (start_ip) begin
                    err_d = 1'b1;
                end
            end
            StDrain: begin
                if (start_ip) begin
                    state_d = StRun;
                    g_d     = '0;
                    launch  = 1'b1;
                end else if (g_q[N-1:0] == DrainEnd) begin
                    state_d = StIdle;
                    g_d     = '0;
                end else begin
                    g_d = g_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                g_d     = '0;
            end
        endcase
    end

    // Stage n picks up a frame when stage n-1 produces its first butterfly output, which is
    // L_n - L_(n-1) = 2^(N-n+1) cycles after stage n-1 started; each stage keeps its own
    // phase so an older frame drains undisturbed while a new one is launched.
    always_comb begin
        stage_start    = '0;
        stage_start[0] = launch;
        for (int i = 1; i < N; i++) begin
            stage_start[i] = act_q[i-1] && (l_q[i-1] == N'((1 << (N - i)) - 1));
        end

        act_d = '0;
        l_d   = l_q;
        sel_d = '0;
        tw_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (stage_start[i]) begin
                act_d[i] = 1'b1;
                l_d[i]   = '0;
            end else if (act_q[i] && (l_q[i] != FrameEnd)) begin
                act_d[i] = 1'b1;
                l_d[i]   = l_q[i] + N'(1);
            end else begin
                l_d[i] = '0;
            end
            if (act_d[i]) begin
                sel_d[i] = l_d[i][N-1-i];
                // bitrev_(n-1)(l >> (N-n+1)) << (N-n) collapses to a fixed bit permutation
                if (sel_d[i]) begin
                    for (int j = 0; j < i; j++) begin
                        tw_d[i][TW-1-j] = l_d[i][N-i+j];
                    end
                end
            end
        end

        sop_d  = (state_d == StRun) && (g_d[N-1:0] == FrameEnd);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            act_q   <= '0;
            l_q     <= '0;
            sel_q   <= '0;
            tw_q    <= '0;
            sop_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            act_q   <= act_d;
            l_q     <= l_d;
            sel_q   <= sel_d;
            tw_q    <= tw_d;
            sop_q   <= sop_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign stage_en    = act_q;
    assign stage_sel   = sel_q;
    assign tw_addr     = tw_q;
    assign start_op    = sop_q;
    assign busy        = busy_q;
    assign err_overrun = err_q;

`ifdef R2SDF_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (sop_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_r2sdf_seq_ctrl.sv
// Scoreboard bench for r2sdf_seq_ctrl (N=3): directed frame scenarios push expected per-cycle
// outputs into a queue; a negedge monitor pops and compares them against the DUT.
module tb_r2sdf_seq_ctrl;

    localparam int N = 3;
    localparam int P = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_ip;
    logic [N-1:0]         stage_en;
    logic [N-1:0]         stage_sel;
    logic [N*(N-1)-1:0]   tw_addr;
    logic                 start_op;
    logic                 busy;
    logic                 err_overrun;
`ifdef R2SDF_FRAME_CNT_EN
    logic [15:0]          frame_cnt;
`endif

    always #5 clk = ~clk;

    r2sdf_seq_ctrl #(
        .N(N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_ip   (start_ip),
        .stage_en   (stage_en),
        .stage_sel  (stage_sel),
        .tw_addr    (tw_addr),
        .start_op   (start_op),
        .busy       (busy),
        .err_overrun(err_overrun)
`ifdef R2SDF_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    typedef struct packed {
        int          cyc;
        logic [2:0]  en;
        logic [2:0]  sel;
        logic [5:0]  tw;
        logic        sop;
        logic        busy;
        logic        err;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   acc_h[$];
    int   rej_h[$];
    int   rst_h[$];
    int   sq[$];
    int   rq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // A frame or strobe survives to cycle c only if no reset was sampled in [s, c-1].
    function automatic bit alive(int s, int c);
        foreach (rst_h[i]) if (rst_h[i] >= s && rst_h[i] < c) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model(int c);
        exp_t e;
        int   lofs [3] = '{0, 4, 6};
        int   tw2 [8]  = '{0, 0, 0, 0, 2, 2, 2, 2};
        int   tw3 [8]  = '{0, 0, 2, 2, 1, 1, 3, 3};
        int   t;
        int   s;
        e     = '0;
        e.cyc = c;
        foreach (acc_h[i]) begin
            s = acc_h[i];
            if (alive(s, c)) begin
                for (int st = 0; st < 3; st++) begin
                    t = c - s - 1 - lofs[st];
                    if (t >= 0 && t < P) begin
                        e.en[st]  = 1'b1;
                        e.sel[st] = t[2-st];
                        if (e.sel[st]) begin
                            e.tw[2*st +: 2] = (st == 2) ? 2'(tw3[t]) :
                                              (st == 1) ? 2'(tw2[t]) : 2'b00;
                        end
                    end
                end
                if (c >= s + 1 && c <= s + 15) e.busy = 1'b1;
                if (c == s + 8) e.sop = 1'b1;
                if (s + 8 < c) e.fc = e.fc + 16'd1;
            end
        end
        foreach (rej_h[i]) if (c == rej_h[i] + 1 && alive(rej_h[i], c)) e.err = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input int c, input logic [15:0] got,
                       input logic [15:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, c, got, want);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_sample cyc=%0d got=none want=checked", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            cur = exp_q.pop_front();
            chk("stage_en", cyc, 16'(stage_en), 16'(cur.en));
            chk("stage_sel", cyc, 16'(stage_sel), 16'(cur.sel));
            chk("tw_addr", cyc, 16'(tw_addr), 16'(cur.tw));
            chk("start_op", cyc, 16'(start_op), 16'(cur.sop));
            chk("busy", cyc, 16'(busy), 16'(cur.busy));
            chk("err_overrun", cyc, 16'(err_overrun), 16'(cur.err));
`ifdef R2SDF_FRAME_CNT_EN
            chk("frame_cnt", cyc, frame_cnt, cur.fc);
`endif
        end
    end

    // sq/rq hold start offsets (accepted / expected-rejected) relative to the scenario start.
    task automatic run_scn(input int span, input int rs);
        int base;
        base = cyc;
        foreach (sq[i]) acc_h.push_back(base + sq[i]);
        foreach (rq[i]) rej_h.push_back(base + rq[i]);
        if (rs >= 0) rst_h.push_back(base + rs);
        for (int c = base + 1; c <= base + span; c++) exp_q.push_back(model(c));
        for (int k = 0; k < span; k++) begin
            start_ip = 1'b0;
            foreach (sq[i]) if (sq[i] == k) start_ip = 1'b1;
            foreach (rq[i]) if (rq[i] == k) start_ip = 1'b1;
            rst = (k == rs);
            @(posedge clk);
            #1;
        end
        start_ip = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start_ip = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset state
        sq.delete(); rq.delete();
        run_scn(4, 0);
        // single frame
        sq.delete(); rq.delete(); sq.push_back(0);
        run_scn(20, -1);
        // back-to-back frames
        sq.delete(); rq.delete(); sq.push_back(0); sq.push_back(8);
        run_scn(28, -1);
        // start mid-frame is rejected
        sq.delete(); rq.delete(); sq.push_back(0); rq.push_back(3);
        run_scn(20, -1);
        // restart during drain
        sq.delete(); rq.delete(); sq.push_back(0); sq.push_back(10);
        run_scn(30, -1);
        // reset at g=5 aborts the frame
        sq.delete(); rq.delete(); sq.push_back(0);
        run_scn(20, 6);
        // three back-to-back frames
        sq.delete(); rq.delete(); sq.push_back(0); sq.push_back(8); sq.push_back(16);
        run_scn(36, -1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_queue got=%0d want=0 pending records", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
